// File: rtl/irq_priority_sequencer.sv
// Interrupt/reset sequencer: picks reset, NMI or a fixed-priority IRQ channel at
// instruction boundaries, drives inject and the vector until the sequence acks.
module irq_priority_sequencer #(
  parameter int                    NUM_IRQ         = 4,
  parameter int                    ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR    = 16'hFFFC,
  parameter logic [ADDR_WIDTH-1:0] NMI_VECTOR      = 16'hFFFA,
  parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR_BASE = 16'hFFE0,
  localparam int                   CH_W            = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  enable,
  input  logic                  nmi,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic [NUM_IRQ-1:0]    chan_en,
  input  logic                  irq_mask,
  input  logic                  instr_boundary,
  input  logic                  ack,
  output logic                  inject,
  output logic [1:0]            int_kind,
  output logic [CH_W-1:0]       int_channel,
  output logic [ADDR_WIDTH-1:0] vector_addr,
  output logic                  reset_running,
  output logic                  nmi_running,
  output logic                  set_i_flag,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    RESET_SEQ = 2'd0,
    IDLE      = 2'd1,
    SERVICE   = 2'd2
  } state_e;

  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_RESET = 2'd1;
  localparam logic [1:0] KIND_NMI   = 2'd2;
  localparam logic [1:0] KIND_IRQ   = 2'd3;

  state_e                state_q, state_d;
  logic                  nmi_prev_q, nmi_prev_d;
  logic                  nmi_latch_q, nmi_latch_d;
  logic                  inject_q, inject_d;
  logic [1:0]            kind_q, kind_d;
  logic [CH_W-1:0]       chan_q, chan_d;
  logic [ADDR_WIDTH-1:0] vec_q, vec_d;
  logic                  reset_run_q, reset_run_d;
  logic                  nmi_run_q, nmi_run_d;
  logic                  set_i_q, set_i_d;

  logic [NUM_IRQ-1:0]    eff_irq;
  logic [CH_W-1:0]       sel_ch;
  logic [ADDR_WIDTH-1:0] irq_vec;
  logic                  nmi_edge;
  logic                  nmi_ack;

  // Lowest-index enabled, unmasked request wins.
  always_comb begin
    eff_irq = irq & chan_en & {NUM_IRQ{~irq_mask}};
    sel_ch  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eff_irq[i]) sel_ch = CH_W'(i);
    end
  end

  assign irq_vec = IRQ_VECTOR_BASE + (ADDR_WIDTH'(sel_ch) << 1);

  // Edge detector ignores enable so a pulse during a stall is never lost;
  // a fresh edge beats a simultaneous NMI ack.
  assign nmi_edge    = nmi & ~nmi_prev_q;
  assign nmi_ack     = enable & ack & (state_q == SERVICE) & (kind_q == KIND_NMI);
  assign nmi_prev_d  = nmi;
  assign nmi_latch_d = nmi_edge | (nmi_latch_q & ~nmi_ack);

  always_comb begin
    state_d     = state_q;
    inject_d    = inject_q;
    kind_d      = kind_q;
    chan_d      = chan_q;
    vec_d       = vec_q;
    reset_run_d = reset_run_q;
    nmi_run_d   = nmi_run_q;
    set_i_d     = 1'b0;

    if (enable) begin
      case (state_q)
        RESET_SEQ: begin
          if (ack) begin
            state_d     = IDLE;
            set_i_d     = 1'b1;
            inject_d    = 1'b0;
            kind_d      = KIND_NONE;
            reset_run_d = 1'b0;
          end
        end
        IDLE: begin
          if (instr_boundary) begin
            if (nmi_latch_q) begin
              state_d   = SERVICE;
              inject_d  = 1'b1;
              kind_d    = KIND_NMI;
              chan_d    = '0;
              vec_d     = NMI_VECTOR;
              nmi_run_d = 1'b1;
            end else if (|eff_irq) begin
              state_d  = SERVICE;
              inject_d = 1'b1;
              kind_d   = KIND_IRQ;
              chan_d   = sel_ch;
              vec_d    = irq_vec;
            end
          end
        end
        SERVICE: begin
          if (ack) begin
            state_d   = IDLE;
            set_i_d   = 1'b1;
            inject_d  = 1'b0;
            kind_d    = KIND_NONE;
            nmi_run_d = 1'b0;
          end
        end
        default: state_d = RESET_SEQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= RESET_SEQ;
      nmi_prev_q  <= 1'b0;
      nmi_latch_q <= 1'b0;
      inject_q    <= 1'b1;
      kind_q      <= KIND_RESET;
      chan_q      <= '0;
      vec_q       <= RESET_VECTOR;
      reset_run_q <= 1'b1;
      nmi_run_q   <= 1'b0;
      set_i_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      nmi_prev_q  <= nmi_prev_d;
      nmi_latch_q <= nmi_latch_d;
      inject_q    <= inject_d;
      kind_q      <= kind_d;
      chan_q      <= chan_d;
      vec_q       <= vec_d;
      reset_run_q <= reset_run_d;
      nmi_run_q   <= nmi_run_d;
      set_i_q     <= set_i_d;
    end
  end

  assign inject        = inject_q;
  assign int_kind      = kind_q;
  assign int_channel   = chan_q;
  assign vector_addr   = vec_q;
  assign reset_running = reset_run_q;
  assign nmi_running   = nmi_run_q;
  assign set_i_flag    = set_i_q;
  assign dbg_state     = state_q;

  // The ack pulse always coincides with the sequence being retired.
  a_pulse_no_inject : assert property (@(posedge clk) disable iff (!nrst) set_i_flag |-> !inject);
  a_inject_has_kind : assert property (@(posedge clk) disable iff (!nrst) inject |-> (int_kind != KIND_NONE));
  a_nmi_run_kind    : assert property (@(posedge clk) disable iff (!nrst) nmi_running |-> (int_kind == KIND_NMI));

endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Directed bench for irq_priority_sequencer: reset, IRQ priority/masking, NMI
// latching across stalls and acks, back-to-back sequences and mid-service reset.
module tb_irq_priority_sequencer;

  logic        clk;
  logic        nrst;
  logic        enable;
  logic        nmi;
  logic [3:0]  irq;
  logic [3:0]  chan_en;
  logic        irq_mask;
  logic        instr_boundary;
  logic        ack;
  logic        inject;
  logic [1:0]  int_kind;
  logic [1:0]  int_channel;
  logic [15:0] vector_addr;
  logic        reset_running;
  logic        nmi_running;
  logic        set_i_flag;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  irq_priority_sequencer dut (
    .clk           (clk),
    .nrst          (nrst),
    .enable        (enable),
    .nmi           (nmi),
    .irq           (irq),
    .chan_en       (chan_en),
    .irq_mask      (irq_mask),
    .instr_boundary(instr_boundary),
    .ack           (ack),
    .inject        (inject),
    .int_kind      (int_kind),
    .int_channel   (int_channel),
    .vector_addr   (vector_addr),
    .reset_running (reset_running),
    .nmi_running   (nmi_running),
    .set_i_flag    (set_i_flag),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it; inputs changed afterwards
  // are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; enable = 1'b1; nmi = 1'b0; irq = 4'b0000; chan_en = 4'b1111;
    irq_mask = 1'b0; instr_boundary = 1'b0; ack = 1'b0;
    tick(); tick();
    checks++;
    if ({inject, int_kind, reset_running, nmi_running, int_channel, set_i_flag} !== {1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got inj=%b kind=%0d rr=%b nr=%b ch=%0d sif=%b, want inj=1 kind=1 rr=1 nr=0 ch=0 sif=0",
               inject, int_kind, reset_running, nmi_running, int_channel, set_i_flag);
    end
    checks++;
    if (vector_addr !== 16'hFFFC) begin failures++; $display("FAIL reset_vector: got %h want fffc", vector_addr); end
    nrst = 1'b1;
    tick(); tick();
    checks++;
    if ({inject, reset_running, int_kind, dbg_state} !== {1'b1, 1'b1, 2'd1, 2'd0}) begin
      failures++;
      $display("FAIL reset_hold: got inj=%b rr=%b kind=%0d st=%0d, want inj=1 rr=1 kind=1 st=0", inject, reset_running, int_kind, dbg_state);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({set_i_flag, inject, int_kind, reset_running, dbg_state} !== {1'b1, 1'b0, 2'd0, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL reset_ack: got sif=%b inj=%b kind=%0d rr=%b st=%0d, want sif=1 inj=0 kind=0 rr=0 st=1",
               set_i_flag, inject, int_kind, reset_running, dbg_state);
    end
    tick();
    checks++;
    if ({set_i_flag, int_kind} !== {1'b0, 2'd0}) begin
      failures++;
      $display("FAIL reset_pulse_width: got sif=%b kind=%0d, want sif=0 kind=0", set_i_flag, int_kind);
    end
  endtask

  task automatic test_irq_priority();
    irq = 4'b0110; chan_en = 4'b1111; irq_mask = 1'b0; instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0; irq = 4'b0000;
    checks++;
    if ({inject, int_kind, int_channel, vector_addr, nmi_running} !== {1'b1, 2'd3, 2'd1, 16'hFFE2, 1'b0}) begin
      failures++;
      $display("FAIL irq_select: got inj=%b kind=%0d ch=%0d vec=%h nr=%b, want inj=1 kind=3 ch=1 vec=ffe2 nr=0",
               inject, int_kind, int_channel, vector_addr, nmi_running);
    end
    // boundary with a higher-priority request while in service must not re-select
    irq = 4'b0001; instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0; irq = 4'b0000;
    checks++;
    if ({inject, int_kind, int_channel, vector_addr} !== {1'b1, 2'd3, 2'd1, 16'hFFE2}) begin
      failures++;
      $display("FAIL irq_service_stable: got inj=%b kind=%0d ch=%0d vec=%h, want inj=1 kind=3 ch=1 vec=ffe2",
               inject, int_kind, int_channel, vector_addr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({set_i_flag, inject, int_kind, dbg_state} !== {1'b1, 1'b0, 2'd0, 2'd1}) begin
      failures++;
      $display("FAIL irq_ack: got sif=%b inj=%b kind=%0d st=%0d, want sif=1 inj=0 kind=0 st=1", set_i_flag, inject, int_kind, dbg_state);
    end
    tick();
    checks++;
    if (set_i_flag !== 1'b0) begin failures++; $display("FAIL irq_ack_pulse_width: got sif=%b want 0", set_i_flag); end
  endtask

  task automatic test_masking();
    irq = 4'b0001; chan_en = 4'b1110; irq_mask = 1'b0; instr_boundary = 1'b1;
    tick();
    checks++;
    if ({inject, int_kind} !== {1'b0, 2'd0}) begin
      failures++; $display("FAIL chan_disabled: got inj=%b kind=%0d, want inj=0 kind=0", inject, int_kind);
    end
    chan_en = 4'b1111; irq_mask = 1'b1;
    tick();
    checks++;
    if ({inject, int_kind} !== {1'b0, 2'd0}) begin
      failures++; $display("FAIL irq_masked: got inj=%b kind=%0d, want inj=0 kind=0", inject, int_kind);
    end
    // request that vanishes before the boundary is never taken
    irq_mask = 1'b0; instr_boundary = 1'b0; irq = 4'b0100;
    tick();
    irq = 4'b0000; instr_boundary = 1'b1;
    tick();
    checks++;
    if ({inject, int_kind} !== {1'b0, 2'd0}) begin
      failures++; $display("FAIL irq_not_latched: got inj=%b kind=%0d, want inj=0 kind=0", inject, int_kind);
    end
    irq = 4'b0001;
    tick();
    instr_boundary = 1'b0; irq = 4'b0000;
    checks++;
    if ({inject, int_kind, int_channel, vector_addr} !== {1'b1, 2'd3, 2'd0, 16'hFFE0}) begin
      failures++;
      $display("FAIL irq_chan0: got inj=%b kind=%0d ch=%0d vec=%h, want inj=1 kind=3 ch=0 vec=ffe0", inject, int_kind, int_channel, vector_addr);
    end
    ack = 1'b1; tick(); ack = 1'b0; tick();
  endtask

  task automatic test_nmi_stall();
    irq = 4'b1000; chan_en = 4'b1111; irq_mask = 1'b0; enable = 1'b0; instr_boundary = 1'b1;
    tick();
    nmi = 1'b1; tick();
    nmi = 1'b0; tick(); tick(); tick();
    checks++;
    if ({inject, int_kind, dbg_state} !== {1'b0, 2'd0, 2'd1}) begin
      failures++; $display("FAIL stall_frozen: got inj=%b kind=%0d st=%0d, want inj=0 kind=0 st=1", inject, int_kind, dbg_state);
    end
    enable = 1'b1;
    tick();
    instr_boundary = 1'b0;
    checks++;
    if ({inject, int_kind, nmi_running, vector_addr} !== {1'b1, 2'd2, 1'b1, 16'hFFFA}) begin
      failures++;
      $display("FAIL nmi_wins: got inj=%b kind=%0d nr=%b vec=%h, want inj=1 kind=2 nr=1 vec=fffa", inject, int_kind, nmi_running, vector_addr);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({set_i_flag, nmi_running, int_kind, inject} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL nmi_ack: got sif=%b nr=%b kind=%0d inj=%b, want sif=1 nr=0 kind=0 inj=0", set_i_flag, nmi_running, int_kind, inject);
    end
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    checks++;
    if ({inject, int_kind, int_channel, vector_addr, nmi_running} !== {1'b1, 2'd3, 2'd3, 16'hFFE6, 1'b0}) begin
      failures++;
      $display("FAIL irq_after_nmi: got inj=%b kind=%0d ch=%0d vec=%h nr=%b, want inj=1 kind=3 ch=3 vec=ffe6 nr=0",
               inject, int_kind, int_channel, vector_addr, nmi_running);
    end
    // ack while stalled is ignored and no pulse is produced
    enable = 1'b0; ack = 1'b1;
    tick();
    checks++;
    if ({set_i_flag, inject, int_kind} !== {1'b0, 1'b1, 2'd3}) begin
      failures++; $display("FAIL stall_ack_ignored: got sif=%b inj=%b kind=%0d, want sif=0 inj=1 kind=3", set_i_flag, inject, int_kind);
    end
    enable = 1'b1; irq = 4'b0000;
    tick();
    ack = 1'b0;
    checks++;
    if ({set_i_flag, inject} !== {1'b1, 1'b0}) begin
      failures++; $display("FAIL stall_ack_release: got sif=%b inj=%b, want sif=1 inj=0", set_i_flag, inject);
    end
    tick();
  endtask

  task automatic test_nmi_ack_edge();
    nmi = 1'b1; tick();
    nmi = 1'b0; instr_boundary = 1'b1; tick();
    instr_boundary = 1'b0;
    checks++;
    if ({int_kind, nmi_running} !== {2'd2, 1'b1}) begin
      failures++; $display("FAIL nmi_edge_entry: got kind=%0d nr=%b, want kind=2 nr=1", int_kind, nmi_running);
    end
    nmi = 1'b1; ack = 1'b1;
    tick();
    nmi = 1'b0; ack = 1'b0;
    checks++;
    if ({set_i_flag, int_kind} !== {1'b1, 2'd0}) begin
      failures++; $display("FAIL nmi_edge_ack: got sif=%b kind=%0d, want sif=1 kind=0", set_i_flag, int_kind);
    end
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    checks++;
    if ({inject, int_kind, nmi_running, vector_addr} !== {1'b1, 2'd2, 1'b1, 16'hFFFA}) begin
      failures++;
      $display("FAIL nmi_relatch: got inj=%b kind=%0d nr=%b vec=%h, want inj=1 kind=2 nr=1 vec=fffa", inject, int_kind, nmi_running, vector_addr);
    end
    ack = 1'b1; tick(); ack = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    ack = 1'b1;
    tick();
    checks++;
    if ({set_i_flag, inject} !== {1'b0, 1'b0}) begin
      failures++; $display("FAIL idle_ack_ignored: got sif=%b inj=%b, want sif=0 inj=0", set_i_flag, inject);
    end
    irq = 4'b1100; instr_boundary = 1'b1;
    tick();
    ack = 1'b0; instr_boundary = 1'b0;
    checks++;
    if ({set_i_flag, int_kind, int_channel, vector_addr} !== {1'b0, 2'd3, 2'd2, 16'hFFE4}) begin
      failures++;
      $display("FAIL ack_with_boundary: got sif=%b kind=%0d ch=%0d vec=%h, want sif=0 kind=3 ch=2 vec=ffe4", set_i_flag, int_kind, int_channel, vector_addr);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    irq = 4'b1000; instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    checks++;
    if ({int_kind, int_channel, vector_addr} !== {2'd3, 2'd3, 16'hFFE6}) begin
      failures++; $display("FAIL back_to_back: got kind=%0d ch=%0d vec=%h, want kind=3 ch=3 vec=ffe6", int_kind, int_channel, vector_addr);
    end
    ack = 1'b1; tick(); ack = 1'b0; irq = 4'b0000; tick();
  endtask

  task automatic test_reset_mid_service();
    irq = 4'b0010; instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0; irq = 4'b0000;
    nmi = 1'b1;
    tick();
    checks++;
    if ({int_kind, int_channel} !== {2'd3, 2'd1}) begin
      failures++; $display("FAIL mid_service_setup: got kind=%0d ch=%0d, want kind=3 ch=1", int_kind, int_channel);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({inject, int_kind, reset_running, nmi_running, int_channel, set_i_flag, vector_addr, dbg_state} !==
        {1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 16'hFFFC, 2'd0}) begin
      failures++;
      $display("FAIL async_reset: got inj=%b kind=%0d rr=%b nr=%b ch=%0d sif=%b vec=%h st=%0d, want inj=1 kind=1 rr=1 nr=0 ch=0 sif=0 vec=fffc st=0",
               inject, int_kind, reset_running, nmi_running, int_channel, set_i_flag, vector_addr, dbg_state);
    end
    nmi = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    checks++;
    if ({inject, int_kind} !== {1'b0, 2'd0}) begin
      failures++; $display("FAIL nmi_latch_cleared: got inj=%b kind=%0d, want inj=0 kind=0", inject, int_kind);
    end
  endtask

  initial begin
    test_reset();
    test_irq_priority();
    test_masking();
    test_nmi_stall();
    test_nmi_ack_edge();
    test_back_to_back();
    test_reset_mid_service();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 ns");
    $fatal(1);
  end

endmodule
